// File: rtl/md_ctrl_pkg.sv
// Shared decode fields, function codes and latency defaults for the mult/div
// sequencer and its HI/LO registers.
package md_ctrl_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    // Encoding matches func[1:0] of the four mult/div instructions.
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

    typedef enum logic {ST_IDLE, ST_BUSY} md_state_t;

    function automatic logic md_is_muldiv(input logic [5:0] fn);
        return fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    endfunction

    function automatic logic md_is_class(input logic [5:0] fn);
        return md_is_muldiv(fn) || (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// Pipeline <-> mult/div unit signals: D/E instruction words, forwarded
// operands, and the stall/busy/read-data returned by the unit.
interface md_ctrl_if;
    logic [31:0] ir_d;
    logic [31:0] ir_e;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        stall_md;
    logic        busy;
    logic [31:0] md_out;

    modport master (output ir_d, ir_e, rs_e, rt_e, input stall_md, busy, md_out);
    modport slave  (input ir_d, ir_e, rs_e, rt_e, output stall_md, busy, md_out);
endinterface

// File: rtl/md_ctrl_datapath.sv
// Combinational HI/LO result from the latched operands; raises hold on a
// zero divisor so the registers keep their old contents.
module md_datapath
    import md_ctrl_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        hold
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_nz;
    logic        [31:0] b_div;
    logic               ovf;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'h0, a} * {32'h0, b};

    // Dividing the overflow case by 1 instead of -1 yields exactly
    // quotient 0x80000000, remainder 0, with no out-of-range arithmetic.
    assign ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign b_nz  = (b == 32'h0) ? 32'h1 : b;
    assign b_div = ovf ? 32'h1 : b_nz;

    assign q_s = $signed(a) / $signed(b_div);
    assign r_s = $signed(a) % $signed(b_div);
    assign q_u = a / b_nz;
    assign r_u = a % b_nz;

    always_comb begin
        hi_next = 32'h0;
        lo_next = 32'h0;
        hold    = 1'b0;
        case (op)
            MD_MULT:  begin hi_next = prod_s[63:32]; lo_next = prod_s[31:0]; end
            MD_MULTU: begin hi_next = prod_u[63:32]; lo_next = prod_u[31:0]; end
            MD_DIV:   begin hi_next = r_s; lo_next = q_s; hold = (b == 32'h0); end
            MD_DIVU:  begin hi_next = r_u; lo_next = q_u; hold = (b == 32'h0); end
            default:  ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Mult/div sequencer: starts ops from E, counts fixed latency, owns HI/LO and
// stalls D whenever an HI/LO-class instruction would hit a busy unit.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    md_ctrl_if.slave   bus
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    md_state_t   state;
    logic [3:0]  cnt;
    md_op_t      op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;

    logic [5:0]  op_d, fn_d, op_e, fn_e;
    logic        class_d, spec_e, start, mthi_e, mtlo_e, mfhi_e, mflo_e;
    md_op_t      op_e_md;
    logic [31:0] hi_next, lo_next;
    logic        hold;
    logic        unused_ir;

    assign op_d = bus.ir_d[OP_HI:OP_LO];
    assign fn_d = bus.ir_d[FN_HI:FN_LO];
    assign op_e = bus.ir_e[OP_HI:OP_LO];
    assign fn_e = bus.ir_e[FN_HI:FN_LO];
    assign unused_ir = ^{bus.ir_d[RS_HI:6], bus.ir_e[RS_HI:6]};

    assign class_d = (op_d == OP_SPECIAL) && md_is_class(fn_d);
    assign spec_e  = (op_e == OP_SPECIAL);
    assign mthi_e  = spec_e && (fn_e == FN_MTHI);
    assign mtlo_e  = spec_e && (fn_e == FN_MTLO);
    assign mfhi_e  = spec_e && (fn_e == FN_MFHI);
    assign mflo_e  = spec_e && (fn_e == FN_MFLO);
    assign op_e_md = md_op_t'(fn_e[1:0]);

    // Gating with reset keeps stall_md low for the whole reset window.
    assign start = spec_e && md_is_muldiv(fn_e) && (state == ST_IDLE) && !reset;

    md_datapath u_dp (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .hi_next (hi_next),
        .lo_next (lo_next),
        .hold    (hold)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= 4'h0;
            op_q   <= MD_MULT;
            a_q    <= 32'h0;
            b_q    <= 32'h0;
            hi_q   <= 32'h0;
            lo_q   <= 32'h0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_BUSY;
                        busy_q <= 1'b1;
                        cnt    <= (op_e_md inside {MD_MULT, MD_MULTU}) ? MUL_CNT : DIV_CNT;
                        a_q    <= bus.rs_e;
                        b_q    <= bus.rt_e;
                        op_q   <= op_e_md;
                    end else if (mthi_e) begin
                        hi_q <= bus.rs_e;
                    end else if (mtlo_e) begin
                        lo_q <= bus.rs_e;
                    end
                end
                ST_BUSY: begin
                    // New mult/div or mthi/mtlo in E is ignored until completion.
                    cnt <= cnt - 4'h1;
                    if (cnt == 4'h1) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        if (!hold) begin
                            hi_q <= hi_next;
                            lo_q <= lo_next;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.stall_md = class_d && (start || busy_q);

    always_comb begin
        bus.md_out = 32'h0;
        if (mfhi_e)      bus.md_out = hi_q;
        else if (mflo_e) bus.md_out = lo_q;
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: constant-result table, hand-written stall,
// mthi/mtlo, back-to-back and reset sequences, then random traffic vs a model.
module tb_md_ctrl;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] ADDU  = 32'h0000_0021;
    localparam logic [31:0] MFHI  = 32'h0000_0010;
    localparam logic [31:0] MTHI  = 32'h0000_0011;
    localparam logic [31:0] MFLO  = 32'h0000_0012;
    localparam logic [31:0] MTLO  = 32'h0000_0013;
    localparam logic [31:0] MULT  = 32'h0000_0018;
    localparam logic [31:0] MULTU = 32'h0000_0019;
    localparam logic [31:0] DIV   = 32'h0000_001A;
    localparam logic [31:0] DIVU  = 32'h0000_001B;
    localparam logic [31:0] FAKE  = 32'h2000_0018;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_ctrl_if bus ();

    md_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: HI/LO, remaining busy cycles, pending operation.
    logic [31:0] m_hi, m_lo, m_a, m_b, m_ir;
    int          m_rem;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic spec_fn(input logic [31:0] ir, input logic [5:0] fn);
        return (ir[31:26] == 6'h0) && (ir[5:0] == fn);
    endfunction

    function automatic logic is_muldiv(input logic [31:0] ir);
        return (ir[31:26] == 6'h0) && (ir[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    function automatic logic is_class(input logic [31:0] ir);
        return is_muldiv(ir) || ((ir[31:26] == 6'h0) && (ir[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13}));
    endfunction

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_ir = 0; m_rem = 0;
    endtask

    task automatic model_finish();
        int sa, sb;
        longint p;
        logic [63:0] pu;
        sa = m_a;
        sb = m_b;
        if (spec_fn(m_ir, 6'h18)) begin
            p = longint'(sa) * longint'(sb);
            m_hi = p[63:32]; m_lo = p[31:0];
        end else if (spec_fn(m_ir, 6'h19)) begin
            pu = {32'h0, m_a} * {32'h0, m_b};
            m_hi = pu[63:32]; m_lo = pu[31:0];
        end else if (spec_fn(m_ir, 6'h1A)) begin
            if (m_b == 0) ;
            else if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
                m_lo = 32'h8000_0000; m_hi = 0;
            end else begin
                m_lo = sa / sb; m_hi = sa % sb;
            end
        end else if (m_b != 0) begin
            m_lo = m_a / m_b; m_hi = m_a % m_b;
        end
    endtask

    task automatic model_edge(input logic [31:0] e, input logic [31:0] a, input logic [31:0] b);
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) model_finish();
        end else if (is_muldiv(e)) begin
            m_rem = (e[5:0] inside {6'h18, 6'h19}) ? 5 : 10;
            m_ir = e; m_a = a; m_b = b;
        end else if (spec_fn(e, 6'h11)) m_hi = a;
        else if (spec_fn(e, 6'h13)) m_lo = a;
    endtask

    // One pipeline cycle: drive, check against model, clock, advance model.
    task automatic tick(input logic [31:0] d, input logic [31:0] e, input logic [31:0] a,
                        input logic [31:0] b, output logic st, output logic bs,
                        output logic [31:0] mo);
        logic [31:0] exp_mo;
        bus.ir_d = d; bus.ir_e = e; bus.rs_e = a; bus.rt_e = b;
        #1;
        st = bus.stall_md; bs = bus.busy; mo = bus.md_out;
        exp_mo = spec_fn(e, 6'h10) ? m_hi : spec_fn(e, 6'h12) ? m_lo : 32'h0;
        chk("model_busy", {31'h0, bs}, {31'h0, m_rem > 0});
        chk("model_stall", {31'h0, st}, {31'h0, is_class(d) && (m_rem > 0 || is_muldiv(e))});
        chk("model_md_out", mo, exp_mo);
        @(posedge clk);
        model_edge(e, a, b);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rnd_ir();
        logic [31:0] fns [8];
        logic [31:0] r;
        fns = '{MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU};
        r = $urandom;
        case ($urandom_range(11))
            8:  return NOP;
            9:  return ADDU;
            10: return FAKE;
            11: return {6'h0, r[19:0], 6'h12};
            default: return fns[$urandom_range(7)];
        endcase
    endfunction

    initial begin
        logic st, bs;
        logic [31:0] mo;
        int c;

        tbl[0] = '{MULT,  32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        tbl[1] = '{MULTU, 32'hFFFF_FFFE, 32'h3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
        tbl[2] = '{DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        tbl[3] = '{DIVU,  32'h7,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        tbl[4] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 10};
        tbl[5] = '{DIVU,  32'd100,       32'd7,         32'h2,         32'hE,         10};
        tbl[6] = '{MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        tbl[7] = '{DIV,   32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 10};

        model_reset();
        bus.ir_d = MFLO; bus.ir_e = MULT; bus.rs_e = 0; bus.rt_e = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_stall", {31'h0, bus.stall_md}, 32'h0);
        bus.ir_e = MFHI;
        #1;
        chk("rst_md_out", bus.md_out, 32'h0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            tick(NOP, tbl[i].ir, tbl[i].a, tbl[i].b, st, bs, mo);
            c = 0;
            for (int k = 0; k < 40; k++) begin
                tick(NOP, NOP, 0, 0, st, bs, mo);
                if (!bs) break;
                c++;
            end
            chk("tbl_busy_cycles", 32'(c), 32'(tbl[i].cyc));
            tick(NOP, MFHI, 0, 0, st, bs, mo);
            chk("tbl_hi", mo, tbl[i].hi);
            tick(NOP, MFLO, 0, 0, st, bs, mo);
            chk("tbl_lo", mo, tbl[i].lo);
        end

        // mflo in D behind a mult in E: stall start cycle + 5 busy cycles.
        tick(MFLO, MULT, 32'h10, 32'h20, st, bs, mo);
        c = st ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            tick(MFLO, NOP, 0, 0, st, bs, mo);
            if (!st) break;
            c++;
        end
        chk("stall_len", 32'(c), 32'd6);
        tick(ADDU, MFLO, 0, 0, st, bs, mo);
        chk("stall_new_lo", mo, 32'h200);

        tick(NOP, MULT, 3, 3, st, bs, mo);
        tick(ADDU, NOP, 0, 0, st, bs, mo);
        chk("addu_no_stall", {31'h0, st}, 32'h0);
        chk("addu_busy", {31'h0, bs}, 32'h1);
        for (int k = 0; k < 20 && bs; k++) tick(NOP, NOP, 0, 0, st, bs, mo);

        tick(NOP, MTHI, 32'h1234_5678, 0, st, bs, mo);
        tick(NOP, MFHI, 0, 0, st, bs, mo);
        chk("mthi", mo, 32'h1234_5678);
        tick(NOP, MTLO, 32'h9ABC_DEF0, 0, st, bs, mo);
        tick(NOP, MFLO, 0, 0, st, bs, mo);
        chk("mtlo", mo, 32'h9ABC_DEF0);

        // Back-to-back mults: second waits in D, then runs once.
        tick(MULT, MULT, 3, 4, st, bs, mo);
        c = st ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            tick(MULT, NOP, 0, 0, st, bs, mo);
            if (!st) break;
            c++;
        end
        chk("b2b_stall_len", 32'(c), 32'd6);
        tick(NOP, MULT, 5, 6, st, bs, mo);
        c = 0;
        for (int k = 0; k < 20; k++) begin
            tick(NOP, NOP, 0, 0, st, bs, mo);
            if (!bs) break;
            c++;
        end
        chk("b2b_busy_cycles", 32'(c), 32'd5);
        tick(NOP, MFLO, 0, 0, st, bs, mo);
        chk("b2b_lo", mo, 32'd30);
        chk("b2b_idle", {31'h0, bs}, 32'h0);
        tick(NOP, MFHI, 0, 0, st, bs, mo);
        chk("b2b_hi", mo, 32'h0);

        // Async reset in the third busy cycle of a div.
        tick(NOP, MTHI, 32'hAAAA_5555, 0, st, bs, mo);
        tick(NOP, DIV, 100, 7, st, bs, mo);
        tick(NOP, NOP, 0, 0, st, bs, mo);
        tick(NOP, NOP, 0, 0, st, bs, mo);
        bus.ir_d = MFLO; bus.ir_e = NOP;
        #1;
        chk("pre_rst_stall", {31'h0, bus.stall_md}, 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("mid_rst_stall", {31'h0, bus.stall_md}, 32'h0);
        bus.ir_e = MFHI;
        #1;
        chk("mid_rst_hi", bus.md_out, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick(NOP, MFHI, 0, 0, st, bs, mo);
        chk("post_rst_hi", mo, 32'h0);
        tick(NOP, MFLO, 0, 0, st, bs, mo);
        chk("post_rst_lo", mo, 32'h0);

        for (int k = 0; k < 400; k++)
            tick(rnd_ir(), rnd_ir(), rnd_val(), rnd_val(), st, bs, mo);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
